// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and request classification helpers
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // Stores only know B/H/W; loads add the unsigned byte/half variants.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
    return !ok;
  endfunction

  // funct3[1:0] carries the access size for every legal encoding.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte/half lane extraction with extension and sub-word store merge
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte and half out of the memory word.
  always_comb begin
    byte_v = word_i[7:0];
    case (off_i)
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      2'd3:    byte_v = word_i[31:24];
      default: byte_v = word_i[7:0];
    endcase
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extend the selected lane according to the load flavour.
  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_o = {24'h0, byte_v};
      F3_H:    load_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_o = {16'h0, half_v};
      default: load_o = word_i;
    endcase
  end

  // Replace the addressed lane of the old word with the store data.
  always_comb begin
    merge_o = word_i;
    case (funct3_i[1:0])
      2'b00: begin
        case (off_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      2'b01: begin
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator with read-modify-write for sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_e       state_q, state_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic [2:0]       f3_q, f3_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [31:0]      wd_q, wd_d;

  logic             req_err;
  logic [31:0]      lane_load;
  logic [31:0]      lane_merge;

  lsu_lane u_lane (
    .word_i   (mem_rd),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .wdata_i  ({16'h0, wdata_q}),
    .load_o   (lane_load),
    .merge_o  (lane_merge)
  );

  // Classify the incoming request; any error skips the memory entirely.
  always_comb begin
    req_err = f3_illegal(req_we, req_funct3) |
              misaligned(req_funct3, req_addr[1:0]) |
              (|req_addr[31:IDX_W+2]);
  end

  // Next-state and register-update logic of the access sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[IDX_W+1:0];
          f3_d    = req_funct3;
          wdata_d = req_wdata[15:0];
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err) begin
            state_d = ST_RESP;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_funct3 == F3_W) begin
            wd_d    = req_wdata;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_MERGE;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = lane_load;
        state_d = ST_RESP;
      end
      ST_MERGE: begin
        wd_d    = lane_merge;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      wdata_q <= 16'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      wd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // Handshake and memory-port outputs decoded from the current state.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_we     = (state_q == ST_WRITE) & rst;
    mem_wd     = wd_q;
    mem_a      = (state_q == ST_IDLE) ? 32'h0
                                      : {{(30-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface for the pipelined RISC-V core. It sits in the MEM stage and turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-indexed accesses on the data memory port. That port offers only a combinational word read and a whole-word write enable. The unit performs byte/halfword extraction with sign or zero extension, and performs read-modify-write for sub-word stores. It stalls the pipeline through a valid/ready handshake.

## Interface
Parameters:
- IDX_W, 10, data-memory word-index width (1024 words); usable byte range is 0 .. 2^(IDX_W+2)-1.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2), low bits used for SB/SH.
- resp_valid  out  1  one-cycle pulse at completion.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; misaligned, illegal funct3, or out-of-range address.
- mem_we  out  1  data-memory write enable.
- mem_a  out  32  word index, zero-extended: {0, addr[IDX_W+1:2]}.
- mem_wd  out  32  data-memory write data.
- mem_rd  in  32  data-memory combinational read data for mem_a.

## Operation
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, latch addr, funct3, we and wdata.
  - Classify the request, then go to RESP with err=1 if it is an error, else LOAD (load), WRITE (SW), or MERGE (SB/SH).
- Error conditions:
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
  - LH/LHU/SH with addr[0]≠0.
  - LW/SW with addr[1:0]≠0.
  - addr[31:IDX_W+2]≠0.
  - An errored request makes no memory access.
- LOAD
  - Select the lane of mem_rd (byte by addr[1:0], half by addr[1]).
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; LW takes the word.
  - Register the result into resp_rdata, then go to RESP.
- MERGE: register merged word into mem_wd, i.e. mem_rd with the addressed byte (SB) or half (SH) replaced by req_wdata[7:0] or [15:0]; go to WRITE.
- WRITE
  - mem_we=1, with mem_wd = merged word or req_wdata (SW).
  - Then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- No response backpressure; the pipeline holds off issue using req_ready.
- mem_we = (state==WRITE) & rst. A reset asserted during WRITE suppresses the write in that cycle.
- mem_a is driven from the latched address in all states; 0 in IDLE and after reset.

## Timing
- Request accepted at edge T (IDLE, req_valid=1).
- Latency from acceptance to resp_valid:
  - error: resp_valid during cycle T+1.
  - load: LOAD in T+1, resp_valid in T+2.
  - SW: mem_we in T+1, resp_valid in T+2.
  - SB/SH: MERGE in T+1, mem_we in T+2, resp_valid in T+3.
- A new request is accepted no earlier than the cycle after RESP; back-to-back throughput is 1 load per 3 cycles.
- Store-then-load to the same word: the load issues after the write edge, so it observes the new data.
- Reset (rst=0 sampled at an edge):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0; req_ready=1 after release.
  - An in-flight request is dropped with no response.
- req_* inputs are ignored outside IDLE.

## Structure
- Package lsu_pkg holds:
  - funct3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
  - The state encoding.
- Sub-module lsu_lane: combinational; given a word, addr[1:0] and funct3, it produces the extended load value and the store-merged word.
- Top level holds the FSM and the registers.

## Test plan
- Word 10 preloaded 0x80FF1234.
  - LB addr 0x28 -> resp_rdata 0x00000034, err 0, resp_valid at T+2.
  - LB 0x2B -> 0xFFFFFF80.
  - LHU 0x2A -> 0x000080FF.
  - LH 0x2A -> 0xFFFF80FF.
- SW addr 0x00 data 0xDEADBEEF -> mem_we=1 for one cycle at T+1, mem_a=0, mem_wd=0xDEADBEEF; following LW returns 0xDEADBEEF.
- Word 0 = 0x00000007; SB addr 0x02 data 0x000000AB -> single write of 0x00AB0007 at T+2; SH 0x00 data 0x5555 then gives 0x00AB5555.
- Error cases, each -> resp_valid at T+1, err=1, mem_we never asserted, memory unchanged:
  - LW 0x22.
  - SH 0x01.
  - funct3 011 load.
  - addr 0x00001000 with IDX_W=10.
- rst=0 asserted in the WRITE cycle of SB -> no write, outputs at reset values, no resp_valid; next request completes normally.
- req_valid held high continuously with alternating LW/SW -> req_ready toggles per FSM, exactly one response per accepted request, no accepted request lost.
